// File: rtl/core_lsu_dm_arb.sv
// core_lsu_dm_arb: in-order arbiter of the two LSU M2 pipes onto the dram-manager we/op channels.
// Pipe 0 is older and always wins; done_q tracks per-pipe completion while the group is stalled.
module core_lsu_dm_arb #(
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [1:0]             req_valid_i,
    input  logic [1:0][2:0]        req_op_i,
    input  logic [1:0]             req_uncached_i,
    input  logic [1:0][ADDR_W-1:0] req_addr_i,
    input  logic [1:0][31:0]       req_wdata_i,
    input  logic [1:0][3:0]        req_strobe_i,
    output logic                   busy_o,
    output logic [1:0]             done_o,
    output logic [1:0][31:0]       rdata_o,
    output logic                   dm_we_valid_o,
    input  logic                   dm_we_ready_i,
    output logic                   dm_op_valid_o,
    input  logic                   dm_op_ready_i,
    output logic [ADDR_W-1:0]      dm_addr_o,
    output logic [31:0]            dm_wdata_o,
    output logic [3:0]             dm_strobe_o,
    output logic [2:0]             dm_op_o,
    output logic                   dm_uncached_o,
    input  logic [31:0]            dm_rdata_i
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        done_q;
    logic [1:0][31:0]  rdata_q;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_strobe;
    logic [2:0]        d_op;
    logic              d_unc, d_we;

    logic       draining, any, grant, g_we, valid_any, complete_now, enter_drain;
    logic [1:0] pending, complete_mask;

    // rst gates pending so a reset mid-handshake withdraws the valid immediately
    assign draining      = state_q == DRAIN;
    assign pending       = req_valid_i & ~done_q & {2{~rst}};
    assign any           = |pending;
    assign grant         = ~pending[0];
    assign g_we          = req_op_i[grant] == 3'd1;
    assign dm_we_valid_o = draining ? d_we : any & g_we;
    assign dm_op_valid_o = draining ? ~d_we : any & ~g_we;
    assign valid_any     = dm_we_valid_o | dm_op_valid_o;
    assign complete_now  = (dm_we_valid_o & dm_we_ready_i) | (dm_op_valid_o & dm_op_ready_i);
    assign complete_mask = (complete_now & ~draining) ? (2'b01 << grant) : 2'b00;
    assign enter_drain   = ~draining & flush_i & valid_any & ~complete_now;

    assign dm_addr_o     = draining ? d_addr   : any ? req_addr_i[grant]     : '0;
    assign dm_wdata_o    = draining ? d_wdata  : any ? req_wdata_i[grant]    : '0;
    assign dm_strobe_o   = draining ? d_strobe : any ? req_strobe_i[grant]   : '0;
    assign dm_op_o       = draining ? d_op     : any ? req_op_i[grant]       : '0;
    assign dm_uncached_o = draining ? d_unc    : any & req_uncached_i[grant];

    assign busy_o  = draining | |(pending & ~complete_mask);
    assign done_o  = done_q;
    assign rdata_o = rdata_q;

    always_comb begin
        state_d = draining ? (complete_now ? IDLE : DRAIN) :
                  flush_i ? (enter_drain ? DRAIN : IDLE) :
                  |(pending & ~complete_mask) ? ISSUE :
                  (stall_i & (complete_now | state_q == HOLD)) ? HOLD : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            done_q   <= '0;
            rdata_q  <= '0;
            d_addr   <= '0;
            d_wdata  <= '0;
            d_strobe <= '0;
            d_op     <= '0;
            d_unc    <= 1'b0;
            d_we     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (flush_i | ~stall_i | draining) ? 2'b00 : done_q | complete_mask;
            if (complete_mask != 2'b00 && !g_we && req_op_i[grant] == 3'd0 && req_uncached_i[grant])
                rdata_q[grant] <= dm_rdata_i;
            if (enter_drain) begin
                d_addr   <= dm_addr_o;
                d_wdata  <= dm_wdata_o;
                d_strobe <= dm_strobe_o;
                d_op     <= dm_op_o;
                d_unc    <= dm_uncached_o;
                d_we     <= dm_we_valid_o;
            end
        end
    end
endmodule

// File: tb/tb_core_lsu_dm_arb.sv
// tb_core_lsu_dm_arb: directed vector table plus hand-written multi-cycle sequences.
module tb_core_lsu_dm_arb;
    logic             clk = 1'b0;
    logic             rst, stall, flush;
    logic [1:0]       valid, unc;
    logic [1:0][2:0]  op;
    logic [1:0][31:0] addr, wdata, rdata;
    logic [1:0][3:0]  strobe;
    logic             busy, we_valid, we_ready, op_valid, op_ready, dm_unc;
    logic [1:0]       done;
    logic [31:0]      dm_addr, dm_wdata, dm_rdata;
    logic [3:0]       dm_strobe;
    logic [2:0]       dm_op;
    int               total = 0, passed = 0;

    always #5 clk = ~clk;

    core_lsu_dm_arb #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
        .req_valid_i(valid), .req_op_i(op), .req_uncached_i(unc),
        .req_addr_i(addr), .req_wdata_i(wdata), .req_strobe_i(strobe),
        .busy_o(busy), .done_o(done), .rdata_o(rdata),
        .dm_we_valid_o(we_valid), .dm_we_ready_i(we_ready),
        .dm_op_valid_o(op_valid), .dm_op_ready_i(op_ready),
        .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata), .dm_strobe_o(dm_strobe),
        .dm_op_o(dm_op), .dm_uncached_o(dm_unc), .dm_rdata_i(dm_rdata)
    );

    typedef struct {
        logic [1:0]  v;
        logic [2:0]  op0, op1;
        logic [1:0]  unc;
        logic        rw, ro;
        logic        ewe, eop, ebusy;
        logic [31:0] eaddr;
        logic [2:0]  ecode;
    } vec_t;
    vec_t vt[11];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        valid = 2'b00; stall = 1'b0; flush = 1'b0; we_ready = 1'b0; op_ready = 1'b0;
        unc = 2'b00; dm_rdata = '0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        vt[0]  = '{2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   3'd0};
        vt[1]  = '{2'b01, 3'd1, 3'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 3'd1};
        vt[2]  = '{2'b01, 3'd1, 3'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 3'd1};
        vt[3]  = '{2'b10, 3'd0, 3'd1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 3'd1};
        vt[4]  = '{2'b11, 3'd1, 3'd1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 3'd1};
        vt[5]  = '{2'b11, 3'd2, 3'd1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 3'd2};
        vt[6]  = '{2'b10, 3'd0, 3'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h104, 3'd0};
        vt[7]  = '{2'b10, 3'd0, 3'd0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 3'd0};
        vt[8]  = '{2'b01, 3'd0, 3'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 3'd0};
        vt[9]  = '{2'b11, 3'd5, 3'd1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 3'd5};
        vt[10] = '{2'b10, 3'd0, 3'd3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 3'd3};

        rst = 1'b1; stall = 1'b0; flush = 1'b0; valid = '0; op = '0; unc = '0;
        addr[0] = 32'h100; addr[1] = 32'h104;
        wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222;
        strobe[0] = 4'hF; strobe[1] = 4'h3;
        we_ready = 1'b0; op_ready = 1'b0; dm_rdata = '0;
        #2;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset valids", {30'b0, we_valid, op_valid}, 0);
        chk("reset addr", dm_addr, 0);
        chk("reset rdata", rdata[1], 0);
        chk("reset state", 32'(dut.state_q), 0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 11; i++) begin
            valid = vt[i].v; op[0] = vt[i].op0; op[1] = vt[i].op1; unc = vt[i].unc;
            we_ready = vt[i].rw; op_ready = vt[i].ro; stall = 1'b1;
            #2;
            chk($sformatf("vec%0d we_valid", i), 32'(we_valid), 32'(vt[i].ewe));
            chk($sformatf("vec%0d op_valid", i), 32'(op_valid), 32'(vt[i].eop));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].ebusy));
            chk($sformatf("vec%0d addr", i), dm_addr, vt[i].eaddr);
            chk($sformatf("vec%0d op", i), 32'(dm_op), 32'(vt[i].ecode));
            cyc();
            idle(2);
        end

        // zero-wait single write under stall
        valid = 2'b01; op[0] = 3'd1; stall = 1'b1; we_ready = 1'b1;
        #2;
        chk("zw we_valid", 32'(we_valid), 1);
        chk("zw busy", 32'(busy), 0);
        cyc(); #2;
        chk("zw done", 32'(done), 32'b01);
        chk("zw no reissue", 32'(we_valid), 0);
        chk("zw state hold", 32'(dut.state_q), 2);
        idle(2);

        // both pipes write, ready low three cycles
        valid = 2'b11; op[0] = 3'd1; op[1] = 3'd1; stall = 1'b1; we_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("bw wait%0d addr", i), dm_addr, 32'h100);
            chk($sformatf("bw wait%0d busy", i), 32'(busy), 1);
            cyc();
        end
        we_ready = 1'b1;
        #2;
        chk("bw p0 addr", dm_addr, 32'h100);
        chk("bw p0 wdata", dm_wdata, 32'h1111_1111);
        chk("bw p0 busy", 32'(busy), 1);
        cyc(); #2;
        chk("bw p1 done", 32'(done), 32'b01);
        chk("bw p1 addr", dm_addr, 32'h104);
        chk("bw p1 strobe", 32'(dm_strobe), 32'h3);
        chk("bw p1 busy", 32'(busy), 0);
        cyc(); #2;
        chk("bw done", 32'(done), 32'b11);
        chk("bw state hold", 32'(dut.state_q), 2);
        idle(1); #2;
        chk("bw done clear", 32'(done), 0);
        chk("bw state idle", 32'(dut.state_q), 0);
        idle(1);

        // pipe 1 uncached read with five wait cycles
        valid = 2'b10; op[1] = 3'd0; unc = 2'b10; stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk($sformatf("ur wait%0d op_valid", i), 32'(op_valid), 1);
            chk($sformatf("ur wait%0d busy", i), 32'(busy), 1);
            cyc();
        end
        op_ready = 1'b1; dm_rdata = 32'hDEAD_BEEF;
        #2;
        chk("ur ready busy", 32'(busy), 0);
        chk("ur uncached", 32'(dm_unc), 1);
        cyc();
        op_ready = 1'b0; dm_rdata = '0;
        #2;
        chk("ur rdata", rdata[1], 32'hDEAD_BEEF);
        chk("ur done", 32'(done), 32'b10);
        idle(2);

        // cache op then write, stall held after both done
        valid = 2'b11; op[0] = 3'd2; op[1] = 3'd1; stall = 1'b1; we_ready = 1'b1; op_ready = 1'b1;
        #2;
        chk("co op_valid", 32'(op_valid), 1);
        chk("co we_valid", 32'(we_valid), 0);
        chk("co addr", dm_addr, 32'h100);
        cyc(); #2;
        chk("co p1 we_valid", 32'(we_valid), 1);
        chk("co p1 addr", dm_addr, 32'h104);
        chk("co state issue", 32'(dut.state_q), 1);
        for (int i = 0; i < 2; i++) begin
            cyc(); #2;
            chk($sformatf("co hold%0d state", i), 32'(dut.state_q), 2);
            chk($sformatf("co hold%0d valids", i), {30'b0, we_valid, op_valid}, 0);
            chk($sformatf("co hold%0d done", i), 32'(done), 32'b11);
        end
        idle(1); #2;
        chk("co done clear", 32'(done), 0);
        chk("co state idle", 32'(dut.state_q), 0);
        idle(1);

        // flush during a pending op drains the latched payload
        valid = 2'b11; op[0] = 3'd2; op[1] = 3'd1; stall = 1'b1;
        #2;
        chk("fl op_valid", 32'(op_valid), 1);
        cyc();
        flush = 1'b1;
        #2;
        chk("fl flush busy", 32'(busy), 1);
        cyc();
        flush = 1'b0; valid = 2'b00; addr[0] = 32'hBAD0; op[0] = 3'd0;
        #2;
        chk("fl state drain", 32'(dut.state_q), 3);
        chk("fl op_valid held", 32'(op_valid), 1);
        chk("fl we_valid", 32'(we_valid), 0);
        chk("fl addr held", dm_addr, 32'h100);
        chk("fl op held", 32'(dm_op), 2);
        chk("fl busy", 32'(busy), 1);
        chk("fl done", 32'(done), 0);
        cyc();
        op_ready = 1'b1;
        #2;
        chk("fl ready addr", dm_addr, 32'h100);
        cyc();
        op_ready = 1'b0;
        #2;
        chk("fl state idle", 32'(dut.state_q), 0);
        chk("fl no p1 issue", {30'b0, we_valid, op_valid}, 0);
        chk("fl busy clear", 32'(busy), 0);
        addr[0] = 32'h100;
        idle(2);

        // async reset mid-write
        valid = 2'b01; op[0] = 3'd1; stall = 1'b1;
        #2;
        chk("rs we_valid", 32'(we_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("rs we_valid off", 32'(we_valid), 0);
        chk("rs busy off", 32'(busy), 0);
        chk("rs addr off", dm_addr, 0);
        chk("rs state", 32'(dut.state_q), 0);
        cyc();
        rst = 1'b0; valid = 2'b00;
        cyc(); #2;
        chk("rs idle after", 32'(dut.state_q), 0);
        chk("rs done", 32'(done), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
